// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: byte-stream instruction issue controller for the 8-bit ALU; ALU_ISSUE_DEBUG_EN adds a register debug read port
module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] REG_INIT = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_data,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_mode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              wb_valid,
  output logic [1:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
`ifdef ALU_ISSUE_DEBUG_EN
  output logic              halted,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
`else
  output logic              halted
`endif
);
  localparam logic [2:0] OP_SUB = 3'd1, OP_CMP = 3'd2, OP_LDI = 3'd6, OP_HALT = 3'd7;
  typedef enum logic [2:0] {FETCH, IMM, EXEC, DONE, HALT} state_t;
  state_t state;
  logic [DATA_W-1:0] r [4];
  logic [DATA_W-1:0] imm_q;
  logic [2:0] op_q;
  logic [1:0] rd_q;
  logic [2:0] op_in;
  assign op_in = instr_data[7:5];
  assign instr_ready = state == FETCH || state == IMM;
  assign wb_valid = state == DONE;
  assign halted = state == HALT;
`ifdef ALU_ISSUE_DEBUG_EN
  assign dbg_data = reset ? REG_INIT : r[dbg_sel];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      r <= '{default: REG_INIT};
      imm_q <= '0;
      op_q <= '0;
      rd_q <= '0;
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_mode <= '0;
      flag_zero <= 1'b0;
      flag_carry <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        FETCH: if (instr_valid) begin
          op_q <= op_in;
          rd_q <= instr_data[4:3];
          if (op_in == OP_HALT) state <= HALT;
          else if (op_in == OP_LDI || instr_data[0]) state <= IMM;
          else begin
            state <= EXEC;
            alu_in1 <= r[instr_data[2:1]];
            alu_in2 <= r[instr_data[4:3]];
            alu_mode <= op_in;
          end
        end
        IMM: if (instr_valid) begin
          imm_q <= instr_data;
          state <= EXEC;
          if (op_q != OP_LDI) begin
            alu_in1 <= instr_data;
            alu_in2 <= r[rd_q];
            alu_mode <= op_q;
          end
        end
        EXEC: begin
          state <= DONE;
          wb_rd <= rd_q;
          if (op_q == OP_LDI) begin
            r[rd_q] <= imm_q;
            wb_data <= imm_q;
          end else if (op_q == OP_CMP) begin
            wb_data <= r[rd_q];
            flag_zero <= alu_zero;
            flag_carry <= alu_carry;
          end else begin
            r[rd_q] <= alu_out;
            wb_data <= alu_out;
            flag_zero <= alu_out == '0;
            // only the arithmetic ops carry; logic ops clear it
            flag_carry <= op_q <= OP_SUB ? alu_carry : 1'b0;
          end
        end
        DONE: state <= FETCH;
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of alu_issue_ctrl against a behavioural 8-bit ALU
module tb_alu_issue_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] instr_data = '0;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [7:0] alu_in1, alu_in2, alu_out, wb_data;
  logic [2:0] alu_mode;
  logic alu_zero, alu_carry, flag_zero, flag_carry, wb_valid, halted;
  logic [1:0] wb_rd;
  int total = 0, pass_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr_data(instr_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .halted(halted)
  );

  logic [8:0] sum9, dif9;
  always_comb begin
    sum9 = {1'b0, alu_in2} + {1'b0, alu_in1};
    dif9 = {1'b0, alu_in2} - {1'b0, alu_in1};
    alu_out = '0;
    alu_carry = 1'b0;
    case (alu_mode)
      3'd0: {alu_carry, alu_out} = sum9;
      3'd1, 3'd2: {alu_carry, alu_out} = dif9;
      3'd3: alu_out = alu_in2 & alu_in1;
      3'd4: alu_out = alu_in2 | alu_in1;
      3'd5: alu_out = alu_in2 ^ alu_in1;
      default: alu_out = '0;
    endcase
    alu_zero = alu_out == 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    instr_data = b;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = instr_ready;
      tick();
    end
    instr_valid = 1'b0;
    chk("accept", acc, 1);
  endtask

  task automatic issue(input logic [7:0] b0, input bit has_imm, input logic [7:0] b1);
    send(b0);
    if (has_imm) send(b1);
  endtask

  task automatic ldi(input logic [1:0] rd, input logic [7:0] v);
    issue({3'b110, rd, 3'b000}, 1'b1, v);
    tick();
    tick();
  endtask

  task automatic chk_wb(input string tag, input logic [1:0] rd, input logic [7:0] d);
    chk({tag, "_wbv"}, wb_valid, 1);
    chk({tag, "_wbrd"}, wb_rd, rd);
    chk({tag, "_wbd"}, wb_data, d);
  endtask

  logic [7:0] sb [3] = '{8'h02, 8'h28, 8'h72};
  logic [7:0] exp_d [3] = '{8'h65, 8'hAB, 8'h00};
  logic [7:0] got_d [3];
  logic [1:0] got_rd [3];
  int idx, wbn;
  logic acc;

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_halt", halted, 0);
    chk("rst_fz", flag_zero, 0);
    chk("rst_fc", flag_carry, 0);
    chk("rst_alu", {alu_in1, alu_in2, 5'b0, alu_mode}, 0);
    chk("rst_wb", {wb_rd, wb_data}, 0);

    issue(8'hC8, 1'b1, 8'h0F);
    chk("ldi_exec_ready", instr_ready, 0);
    chk("ldi_exec_wbv", wb_valid, 0);
    tick();
    chk_wb("ldi", 2'd1, 8'h0F);
    chk("ldi_flags", {flag_zero, flag_carry}, 0);
    chk("ldi_alu", {alu_in1, alu_in2, 5'b0, alu_mode}, 0);
    tick();
    chk("ldi_done_ready", instr_ready, 1);

    ldi(2'd1, 8'hF0);
    issue(8'h09, 1'b1, 8'h20);
    chk("add_in1", alu_in1, 8'h20);
    chk("add_in2", alu_in2, 8'hF0);
    chk("add_mode", alu_mode, 0);
    chk("add_wb_early", wb_valid, 0);
    tick();
    chk_wb("add", 2'd1, 8'h10);
    chk("add_fc", flag_carry, 1);
    chk("add_fz", flag_zero, 0);
    tick();

    ldi(2'd0, 8'h55);
    ldi(2'd2, 8'h55);
    chk("ldi_keeps_fc", flag_carry, 1);
    issue(8'h44, 1'b0, 8'h00);
    chk("cmp_in", {alu_in1, alu_in2}, 16'h5555);
    chk("cmp_mode", alu_mode, 2);
    tick();
    chk_wb("cmp", 2'd0, 8'h55);
    chk("cmp_flags", {flag_zero, flag_carry}, 2'b10);
    tick();
    issue(8'h80, 1'b0, 8'h00);
    chk("cmp_r0_kept", alu_in2, 8'h55);
    tick();
    chk_wb("or", 2'd0, 8'h55);
    tick();

    ldi(2'd3, 8'hA5);
    issue(8'h11, 1'b1, 8'hFF);
    tick();
    chk_wb("add2", 2'd2, 8'h54);
    chk("add2_fc", flag_carry, 1);
    tick();
    issue(8'hBE, 1'b0, 8'h00);
    chk("xor_in", {alu_in1, alu_in2}, 16'hA5A5);
    tick();
    chk_wb("xor", 2'd3, 8'h00);
    chk("xor_flags", {flag_zero, flag_carry}, 2'b10);
    tick();

    idx = 0;
    wbn = 0;
    instr_data = sb[0];
    instr_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 9) chk($sformatf("stream_ready%0d", i), instr_ready, (i % 3 == 0) ? 1 : 0);
      acc = instr_ready && instr_valid;
      tick();
      if (acc) idx++;
      if (idx < 3) instr_data = sb[idx];
      else instr_valid = 1'b0;
      if (wb_valid) begin
        if (wbn < 3) begin
          got_d[wbn] = wb_data;
          got_rd[wbn] = wb_rd;
        end
        wbn++;
      end
    end
    instr_valid = 1'b0;
    chk("stream_wbcount", wbn, 3);
    chk("stream_accepted", idx, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stream_d%0d", k), got_d[k], exp_d[k]);
      chk($sformatf("stream_rd%0d", k), got_rd[k], k);
    end
    chk("stream_flags", {flag_zero, flag_carry}, 2'b10);

    send(8'hE0);
    chk("halt_halted", halted, 1);
    chk("halt_ready", instr_ready, 0);
    instr_data = 8'hC8;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("halt_hold%0d", i), {halted, instr_ready, wb_valid}, 3'b100);
    end
    instr_valid = 1'b0;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    send(8'hC8);
    chk("mid_imm_ready", instr_ready, 1);
    instr_data = 8'h0F;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_alu", {alu_in1, alu_in2, 5'b0, alu_mode}, 0);
    chk("rst2_flags", {flag_zero, flag_carry}, 0);
    chk("rst2_wb", {wb_valid, wb_rd, wb_data}, 0);
    chk("rst2_ctl", {halted, instr_ready}, 2'b01);
    issue(8'h22, 1'b0, 8'h00);
    chk("rst2_opcode_mode", alu_mode, 1);
    tick();
    chk_wb("rst2_sub", 2'd0, 8'h00);
    chk("rst2_sub_fz", flag_zero, 1);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Instruction-issue controller that drives the 8-bit ALU's operand and mode inputs and consumes its result and flags.
- Accepts a byte-wide instruction stream over a valid/ready handshake.
- Decodes each instruction and reads a 4-entry 8-bit register file.
- Presents operands and mode to the ALU, then writes the result back and updates the architectural zero/carry flags.
- Sits between the fetch path and the combinational ALU in the microprocessor datapath.

Parameters:
- DATA_W, 8, datapath width; only 8 is supported.
- REG_INIT, 8'h00, reset value of all four registers R0-R3.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- instr_data  input  8  instruction or immediate byte
- instr_valid  input  1  instr_data is valid
- instr_ready  output  1  controller accepts the byte this cycle
- alu_in1  output  8  ALU operand 1 (source operand)
- alu_in2  output  8  ALU operand 2 (destination register value)
- alu_mode  output  3  ALU mode
- alu_out  input  8  ALU result
- alu_zero  input  1  ALU zero flag (used by CMP only)
- alu_carry  input  1  ALU carry/less-than flag
- flag_zero  output  1  architectural zero flag
- flag_carry  output  1  architectural carry flag
- wb_valid  output  1  one-cycle pulse, instruction retired
- wb_rd  output  2  destination index of the retired instruction
- wb_data  output  8  value written; for CMP, the unchanged R[rd]
- halted  output  1  HALT executed

Behaviour:
- Reset is synchronous and applies at any time, including mid-instruction:
  - state = FETCH; R0-R3 = REG_INIT.
  - flag_zero, flag_carry, wb_valid, halted = 0; wb_rd = 0, wb_data = 0.
  - alu_in1, alu_in2, alu_mode = 0.
  - Any partially fetched instruction is discarded.
- Instruction byte fields:
  - op[7:5], rd[4:3], rs[2:1], imm[0].
  - op 0-5 are ALU ops, passed unchanged as alu_mode: 0 ADD, 1 SUB (R[rd]-src), 2 CMP, 3 AND, 4 OR, 5 XOR.
  - op 6 = LDI; op 7 = HALT.
- src operand:
  - imm=0: src = R[rs].
  - imm=1: src = the next accepted byte.
  - LDI always takes one immediate byte; the imm bit is ignored.
- States:
  - FETCH: instr_ready = 1. On accept, latch the opcode byte.
    - ALU op with imm=1, or LDI -> IMM.
    - ALU op with imm=0 -> EXEC.
    - HALT -> HALT.
  - IMM: instr_ready = 1. Wait for the handshake; the accepted byte is src -> EXEC.
  - EXEC: instr_ready = 0.
    - alu_in1 = src, alu_in2 = R[rd], alu_mode = op. All three are registered, loaded on the edge entering EXEC, and hold until the next EXEC load.
    - At the end of EXEC, capture alu_out and the flags; the register write occurs on that edge -> DONE.
  - DONE: wb_valid = 1 for exactly one cycle, with wb_rd and wb_data -> FETCH.
  - HALT: instr_ready = 0, halted = 1. Leave only by reset.
- Writeback and flag rules:
  - ADD, SUB: R[rd] = alu_out; flag_carry = alu_carry; flag_zero = (alu_out == 0), computed locally.
  - AND, OR, XOR: R[rd] = alu_out; flag_carry = 0; flag_zero = (alu_out == 0).
  - CMP: no register write; flag_zero = alu_zero; flag_carry = alu_carry.
  - LDI: R[rd] = immediate; flags unchanged; no ALU cycle (alu_* unchanged). EXEC is still traversed, so timing is uniform.
- Latency:
  - Opcode accepted in cycle N, imm=0: EXEC in N+1, wb_valid in N+2, next byte accepted in N+3.
  - With an immediate byte accepted in cycle M: wb_valid in M+2.
- Handshake:
  - A byte transfers only when instr_valid && instr_ready.
  - instr_valid while instr_ready=0 is ignored; the source holds the byte.
  - Back-to-back valid bytes are accepted every FETCH/IMM cycle.
- rd == rs is legal; the read uses the pre-write value.

Optional Feature:
- ALU_ISSUE_DEBUG_EN defined:
  - Adds input dbg_sel[1:0] and output dbg_data[7:0].
  - dbg_data = R[dbg_sel], combinational read, showing the post-write value from the DONE cycle onward.
  - dbg_data = REG_INIT during reset.
- ALU_ISSUE_DEBUG_EN not defined: both ports are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then LDI R1,8'h0F (bytes 8'hC8, 8'h0F) -> wb_valid with wb_rd=1, wb_data=8'h0F; flags stay 0; alu_* remain 0.
- R1=8'hF0, then ADD-imm R1,8'h20 (bytes 8'h09, 8'h20); model ALU returns 8'h10, carry 1 -> R1=8'h10, flag_carry=1, flag_zero=0, wb_valid 2 cycles after the immediate accept.
- R0=R2=8'h55, CMP R0,R2 (byte 8'h44); ALU returns zero 1, carry 0 -> wb_data=8'h55, R0 unchanged, flag_zero=1, flag_carry=0.
- XOR R3,R3 (byte 8'hBE) with R3=8'hA5; ALU returns 8'h00 -> R3=0, flag_zero=1, flag_carry=0 even though the prior carry was 1.
- instr_valid held high with a continuous stream of 3 register-operand ops -> instr_ready pattern 1,0,0 repeating; exactly 3 wb_valid pulses; no byte dropped or duplicated.
- HALT (8'hE0), then valid bytes -> instr_ready stays 0, halted=1. Assert reset while in IMM mid-LDI on a separate run -> all outputs return to reset values and the next byte is decoded as an opcode.
